// File: rtl/condlogic_pkg.sv
// rtl/condlogic_pkg.sv - shared condition codes, flag indices and counter width
package condlogic_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
    MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
    HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
    GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
  } cond_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int CNT_W = 16;

endpackage

// File: rtl/condlogic_condcheck.sv
// rtl/condlogic_condcheck.sv - combinational condition evaluation against registered flags
module condcheck
  import condlogic_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n, z, c, v;

  assign n = Flags[FLAG_N];
  assign z = Flags[FLAG_Z];
  assign c = Flags[FLAG_C];
  assign v = Flags[FLAG_V];

  always_comb begin
    CondEx = 1'b0;
    case (cond_t'(Cond))
      EQ: CondEx = z;
      NE: CondEx = ~z;
      CS: CondEx = c;
      CC: CondEx = ~c;
      MI: CondEx = n;
      PL: CondEx = ~n;
      VS: CondEx = v;
      VC: CondEx = ~v;
      HI: CondEx = c & ~z;
      LS: CondEx = ~c | z;
      GE: CondEx = (n == v);
      LT: CondEx = (n != v);
      GT: CondEx = ~z & (n == v);
      LE: CondEx = z | (n != v);
      AL: CondEx = 1'b1;
      NV: CondEx = 1'b0;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/condlogic.sv
// rtl/condlogic.sv - conditional-execution gate, architectural flags and execute/skip counters
module condlogic
  import condlogic_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  input  logic             Valid,
  input  logic             Stall,
  input  logic             Flush,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             CondEx,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] ExecCount,
  output logic [CNT_W-1:0] SkipCount
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic live;
  logic exec;

  condcheck u_condcheck (
    .Cond   (Cond),
    .Flags  (Flags),
    .CondEx (CondEx)
  );

  // Reset gates writes combinationally so nothing escapes during the reset cycle.
  assign live     = Valid & ~Stall & ~Flush & ~reset;
  assign exec     = live & CondEx;
  assign PCSrc    = exec & PCS;
  assign RegWrite = exec & RegW & ~NoWrite;
  assign MemWrite = exec & MemW;

  always_ff @(posedge clk) begin
    if (reset) begin
      Flags     <= 4'b0000;
      ExecCount <= '0;
      SkipCount <= '0;
    end else if (exec) begin
      if (FlagW[1]) Flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
      if (FlagW[0]) Flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
      ExecCount <= ExecCount + CNT_ONE;
    end else if (live) begin
      SkipCount <= SkipCount + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_condlogic.sv
// tb/tb_condlogic.sv - scoreboard bench for condlogic
module tb_condlogic;
  import condlogic_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  Cond, ALUFlags;
  logic [1:0]  FlagW;
  logic        PCS, RegW, MemW, NoWrite, Valid, Stall, Flush;
  logic        PCSrc, RegWrite, MemWrite, CondEx;
  logic [3:0]  Flags;
  logic [15:0] ExecCount, SkipCount;

  condlogic dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite), .Valid(Valid),
    .Stall(Stall), .Flush(Flush), .PCSrc(PCSrc), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .CondEx(CondEx), .Flags(Flags),
    .ExecCount(ExecCount), .SkipCount(SkipCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        pcsrc, regwrite, memwrite, condex;
    logic [3:0]  flags;
    logic [15:0] exec, skip;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0]  m_flags = 4'b0000;
  logic [15:0] m_exec  = 16'd0;
  logic [15:0] m_skip  = 16'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step(input string tag, input logic [3:0] c, input logic [3:0] alu,
                      input logic [1:0] fw, input logic pcs_i, input logic regw_i,
                      input logic memw_i, input logic nw_i, input logic val_i,
                      input logic st_i, input logic fl_i, input logic rst_i);
    exp_t e;
    logic ce, live;
    @(negedge clk);
    Cond = c; ALUFlags = alu; FlagW = fw; PCS = pcs_i; RegW = regw_i; MemW = memw_i;
    NoWrite = nw_i; Valid = val_i; Stall = st_i; Flush = fl_i; reset = rst_i;
    ce   = cond_ok(c, m_flags);
    live = val_i && !st_i && !fl_i && !rst_i;
    e.tag      = tag;
    e.condex   = ce;
    e.pcsrc    = live && ce && pcs_i;
    e.regwrite = live && ce && regw_i && !nw_i;
    e.memwrite = live && ce && memw_i;
    if (rst_i) begin
      m_flags = 4'b0000; m_exec = 16'd0; m_skip = 16'd0;
    end else if (live && ce) begin
      if (fw[1]) m_flags[3:2] = alu[3:2];
      if (fw[0]) m_flags[1:0] = alu[1:0];
      m_exec = m_exec + 16'd1;
    end else if (live) begin
      m_skip = m_skip + 16'd1;
    end
    e.flags = m_flags; e.exec = m_exec; e.skip = m_skip;
    sb.push_back(e);
    #1;
    e = sb[0];
    chk({e.tag, ".CondEx"},   CondEx,   e.condex);
    chk({e.tag, ".PCSrc"},    PCSrc,    e.pcsrc);
    chk({e.tag, ".RegWrite"}, RegWrite, e.regwrite);
    chk({e.tag, ".MemWrite"}, MemWrite, e.memwrite);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".Flags"},     Flags,     e.flags);
    chk({e.tag, ".ExecCount"}, ExecCount, e.exec);
    chk({e.tag, ".SkipCount"}, SkipCount, e.skip);
  endtask

  task automatic peek(input string tag, input logic [3:0] c);
    step(tag, c, 4'hF, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [3:0] sweep_conds[7];

  initial begin
    sweep_conds = '{GE, LT, GT, LE, HI, LS, NV};
    reset = 1'b1; Cond = AL; ALUFlags = 4'h0; FlagW = 2'b00; PCS = 1'b0; RegW = 1'b0;
    MemW = 1'b0; NoWrite = 1'b0; Valid = 1'b0; Stall = 1'b0; Flush = 1'b0;

    step("rst", AL, 4'hF, 2'b11, 1, 1, 1, 0, 1, 0, 0, 1);
    peek("rst_eq", EQ); peek("rst_ne", NE); peek("rst_ge", GE);
    peek("rst_al", AL); peek("rst_nv", NV);

    step("cmp", AL, 4'b0100, 2'b11, 0, 1, 0, 1, 1, 0, 0, 0);
    peek("cmp_eq", EQ);
    step("fail_ne", NE, 4'b1000, 2'b11, 0, 0, 1, 0, 1, 0, 0, 0);
    step("cmp_back2back", AL, 4'b1001, 2'b11, 0, 0, 0, 1, 1, 0, 0, 0);
    step("sees_new", VS, 4'b0000, 2'b11, 1, 1, 0, 0, 1, 0, 0, 0);

    step("rst2", AL, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1);
    step("partial_nz", AL, 4'b1111, 2'b10, 0, 0, 0, 0, 1, 0, 0, 0);
    step("partial_cv", AL, 4'b0000, 2'b01, 0, 0, 0, 0, 1, 0, 0, 0);

    step("stall", AL, 4'b0010, 2'b11, 1, 0, 0, 0, 1, 1, 0, 0);
    step("stall_flush", AL, 4'b0010, 2'b11, 1, 0, 0, 0, 1, 1, 1, 0);
    step("flush", AL, 4'b0010, 2'b11, 1, 1, 1, 0, 1, 0, 1, 0);
    step("invalid", AL, 4'b0010, 2'b11, 1, 1, 1, 0, 0, 0, 0, 0);

    for (int f = 0; f < 16; f++) begin
      step($sformatf("load%0d", f), AL, 4'(f), 2'b11, 0, 0, 0, 1, 1, 0, 0, 0);
      for (int k = 0; k < 7; k++)
        peek($sformatf("f%0d_c%0d", f, sweep_conds[k]), sweep_conds[k]);
    end

    for (int i = 0; i < 300; i++) begin
      logic [31:0] r;
      r = $urandom;
      step($sformatf("rnd%0d", i), r[3:0], r[7:4], r[9:8], r[10], r[11], r[12], r[13],
           r[14] | r[15], r[16] & r[17], r[18] & r[19], (r[23:20] == 4'd0));
    end

    step("rst3", AL, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    reset = 1'b0; Cond = AL; FlagW = 2'b00; PCS = 1'b0; RegW = 1'b0; MemW = 1'b0;
    Valid = 1'b1; Stall = 1'b0; Flush = 1'b0;
    repeat (65535) @(posedge clk);
    m_exec = m_exec + 16'd65535;
    peek("hold_ffff", AL);
    step("wrap", AL, 4'h0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0);
    step("skip_after_wrap", NV, 4'h0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0);
    step("rst_live", AL, 4'hF, 2'b11, 1, 1, 1, 0, 1, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/condlogic.md
CONDLOGIC -- requirements
Module: condlogic

Interface
REQ-001 The block SHALL have a single clock and reset: clk, input, 1, rising-edge clock; reset, input, 1, synchronous active-high reset.
REQ-002 The block SHALL have input ports:
- Cond, input, 4, instruction condition field.
- ALUFlags, input, 4, {N,Z,C,V} from the ALU for the current instruction.
- FlagW, input, 2, flag-write request: [1]=NZ, [0]=CV.
- PCS, input, 1, instruction writes PC.
- RegW, input, 1, instruction writes the register file.
- MemW, input, 1, instruction writes memory.
- NoWrite, input, 1, compare-class instruction; suppresses the register write.
- Valid, input, 1, current inputs describe a live instruction.
- Stall, input, 1, hold the current instruction; it re-presents next cycle.
- Flush, input, 1, kill the current instruction.
REQ-003 The block SHALL have output ports:
- PCSrc, output, 1, gated PC write.
- RegWrite, output, 1, gated register write.
- MemWrite, output, 1, gated memory write.
- CondEx, output, 1, condition passed.
- Flags, output, 4, architectural {N,Z,C,V} register.
- ExecCount, output, 16, executed-instruction counter.
- SkipCount, output, 16, condition-failed counter.

Function
REQ-004 CondEx SHALL be evaluated combinationally against the registered Flags, never against ALUFlags. The condition table is:
- 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C.
- 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
- 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V.
- 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 NV 0.
REQ-005 An instruction SHALL be committing (Live) when Valid & !Stall & !Flush & !reset.
REQ-006 The gated outputs SHALL be:
- PCSrc = Live & CondEx & PCS.
- RegWrite = Live & CondEx & RegW & !NoWrite.
- MemWrite = Live & CondEx & MemW.
REQ-007 Flags[3:2] SHALL load ALUFlags[3:2] at the next rising edge when Live & CondEx & FlagW[1], and otherwise hold.
REQ-008 Flags[1:0] SHALL load ALUFlags[1:0] at the next rising edge when Live & CondEx & FlagW[0], and otherwise hold.
REQ-009 Flag-update latency SHALL be one cycle: the instruction presented in cycle n+1 sees the flags written in cycle n, with no bypass.
REQ-010 ExecCount SHALL increment by 1 when Live & CondEx, and SkipCount SHALL increment by 1 when Live & !CondEx; at most one counter increments per cycle.
REQ-011 Both counters SHALL wrap from 16'hFFFF to 16'h0000 with no sticky overflow.
REQ-012 With Stall and Flush both high, Flush semantics SHALL apply: no write, no flag update, no count.
REQ-013 With Valid low, all gated outputs SHALL be 0, and Flags and counters SHALL hold, regardless of FlagW, PCS, RegW or MemW.

Reset
REQ-014 On any rising edge with reset high, Flags SHALL become 4'b0000, and ExecCount and SkipCount SHALL become 0.
REQ-015 While reset is high, PCSrc, RegWrite and MemWrite SHALL be 0 combinationally.
REQ-016 Reset SHALL take priority over any concurrent flag write or counter increment, including when asserted mid-sequence.
REQ-017 After reset, CondEx SHALL reflect Flags=0000: EQ=0, NE=1, GE=1, AL=1, NV=0.

Structure
REQ-018 A shared package SHALL hold:
- cond_t, a 4-bit enum EQ..NV with the encodings of REQ-004.
- Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- The counter width constant CNT_W=16.
REQ-019 Condition evaluation SHALL live in a purely combinational sub-module condcheck (inputs Cond, Flags; output CondEx), instantiated once.

Verification
REQ-020 Flag-setting compare: after reset, present Cond=AL, FlagW=11, ALUFlags=0100, RegW=1, NoWrite=1, Valid=1 -> RegWrite=0, ExecCount=1; next cycle Flags=0100 and Cond=EQ yields CondEx=1.
REQ-021 Failed condition: with Flags=0100, present Cond=NE, FlagW=11, ALUFlags=1000, MemW=1 -> MemWrite=0, Flags stays 0100, SkipCount increments by 1.
REQ-022 Partial flag write: with Flags=0000, present Cond=AL, FlagW=10, ALUFlags=1111 -> Flags=1100 the next cycle, C and V unchanged.
REQ-023 Stall and Flush:
- Cond=AL, FlagW=11, ALUFlags=0010, PCS=1 with Stall=1 -> PCSrc=0, Flags and counters unchanged.
- Same inputs with Stall=1 and Flush=1 -> identical result.
REQ-024 Signed conditions: across all 16 Flags values, check GE, LT, GT, LE, HI and LS against the REQ-004 table; NV is always 0.
REQ-025 Counter wrap and reset: preload ExecCount=16'hFFFF through 65535 AL instructions, issue one more -> 16'h0000; then assert reset while Valid=1, PCS=1 -> PCSrc=0 and all state cleared.
